// File: rtl/multi_tone_generator.sv
// Multi-channel square/PWM tone generator: a shared sequential divider turns a
// centi-Hz frequency into a clock-count period, applied per channel at period wrap.
module multi_tone_generator #(
    parameter int CLK_HZ   = 125000000,
    parameter int CHANNELS = 4,
    parameter int NUM_W    = 40,
    parameter int CNT_W    = 32,
    parameter int MAX_FREQ = 999999,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [31:0]         cfg_freq,
    input  logic [7:0]          cfg_duty,
    output logic                cfg_err,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] wave_out,
    output logic [CHANNELS-1:0] period_strb
);
    localparam int BC_W = $clog2(NUM_W + 1);
    localparam logic [NUM_W-1:0] NUMER = NUM_W'(64'(CLK_HZ) * 64'd100);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIV    = 2'd1;
    localparam logic [1:0] S_MUL    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    function automatic logic [CNT_W-1:0] scale_duty(input logic [CNT_W-1:0] per,
                                                    input logic [7:0] duty);
        logic [CNT_W+7:0] prod;
        prod = {8'b0, per} * {{CNT_W{1'b0}}, duty};
        return CNT_W'(prod >> 8);
    endfunction

    logic [1:0]       state;
    logic [CH_W-1:0]  chan_r;
    logic [31:0]      freq_r;
    logic [7:0]       duty_r;
    logic [NUM_W-1:0] num_r;
    logic [31:0]      rem_r;
    logic [BC_W-1:0]  bit_cnt;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             bad_req;
    logic             commit;
    logic [32:0]      shifted;
    logic             ge;
    logic [31:0]      diff;

    assign cfg_ready = (state == S_IDLE);
    assign commit    = (state == S_COMMIT);
    assign bad_req   = (cfg_freq > 32'(MAX_FREQ)) || (32'(cfg_chan) >= 32'(CHANNELS));

    // Restoring divide: quotient bits shift into num_r as the numerator shifts out.
    assign shifted = {rem_r, num_r[NUM_W-1]};
    assign ge      = (shifted >= {1'b0, freq_r});
    assign diff    = 32'(shifted - {1'b0, freq_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: if (cfg_valid) begin
                    if (bad_req)              cfg_err <= 1'b1;
                    else if (cfg_freq == '0)  state   <= S_COMMIT;
                    else                      state   <= S_DIV;
                end
                S_DIV:   if (bit_cnt == '0) state <= S_MUL;
                S_MUL:   state <= S_COMMIT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (cfg_valid) begin
                chan_r   <= cfg_chan;
                freq_r   <= cfg_freq;
                duty_r   <= cfg_duty;
                num_r    <= NUMER;
                rem_r    <= '0;
                bit_cnt  <= BC_W'(NUM_W - 1);
                period_r <= '0;
                high_r   <= '0;
            end
            S_DIV: begin
                rem_r   <= ge ? diff : shifted[31:0];
                num_r   <= {num_r[NUM_W-2:0], ge};
                bit_cnt <= bit_cnt - BC_W'(1);
            end
            S_MUL: begin
                period_r <= num_r[CNT_W-1:0];
                high_r   <= scale_duty(num_r[CNT_W-1:0], duty_r);
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CNT_W-1:0] act_per, act_high, pend_per, pend_high, cnt;
        logic             pend_vld;
        logic             run, wrap, load, commit_here;

        assign run         = chan_en[i] && (act_per != '0);
        assign wrap        = run && (cnt == act_per - CNT_W'(1));
        assign load        = pend_vld && (wrap || !run);
        assign commit_here = commit && (chan_r == CH_W'(i));

        // A commit landing on the load cycle stays pending; the load takes the older value.
        always_ff @(posedge clk) begin
            if (rst) begin
                act_per   <= '0;
                act_high  <= '0;
                pend_per  <= '0;
                pend_high <= '0;
                pend_vld  <= 1'b0;
                cnt       <= '0;
            end else begin
                if (load) begin
                    act_per  <= pend_per;
                    act_high <= pend_high;
                end
                if (commit_here) begin
                    pend_per  <= period_r;
                    pend_high <= high_r;
                    pend_vld  <= 1'b1;
                end else if (load) begin
                    pend_vld <= 1'b0;
                end
                if (!run || wrap) cnt <= '0;
                else              cnt <= cnt + CNT_W'(1);
            end
        end

        assign wave_out[i]    = run && (cnt < act_high);
        assign period_strb[i] = run && (cnt == '0);
    end
endmodule

// File: tb/tb_multi_tone_generator.sv
// Directed bench for multi_tone_generator, scaled to a 1 MHz clock so periods stay short.
module tb_multi_tone_generator;
    localparam int CLK_HZ = 1000000;
    localparam int CH     = 3;
    localparam int NUM_W  = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [31:0]   cfg_freq = '0;
    logic [7:0]    cfg_duty = '0;
    logic          cfg_err;
    logic [CH-1:0] chan_en = '1;
    logic [CH-1:0] wave_out;
    logic [CH-1:0] period_strb;

    int n_cmp = 0;
    int n_bad = 0;

    multi_tone_generator #(.CLK_HZ(CLK_HZ), .CHANNELS(CH), .NUM_W(NUM_W), .CNT_W(32),
                           .MAX_FREQ(999999)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_freq(cfg_freq), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
        .chan_en(chan_en), .wave_out(wave_out), .period_strb(period_strb));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int ch, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (period_strb[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called while the current sample is a strobe cycle.
    task automatic measure_from_strobe(input int ch, output int per, output int hi);
        per = -1;
        hi  = int'(wave_out[ch]);
        for (int k = 1; k <= 20000; k++) begin
            tick();
            if (period_strb[ch]) begin
                per = k;
                break;
            end
            hi += int'(wave_out[ch]);
        end
    endtask

    task automatic measure(input int ch, output int per, output int hi);
        bit ok;
        wait_strobe(ch, 20000, ok);
        if (!ok) begin
            per = -1;
            hi  = -1;
        end else begin
            measure_from_strobe(ch, per, hi);
        end
    endtask

    task automatic cfg(input int ch, input int freq, input int duty,
                       output int low, output logic err_t1);
        int g = 0;
        while (!cfg_ready && g < 500) begin
            tick();
            g++;
        end
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_freq  = 32'(freq);
        cfg_duty  = 8'(duty);
        tick();
        cfg_valid = 1'b0;
        err_t1    = cfg_err;
        low       = 0;
        while (!cfg_ready && low < 500) begin
            low++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        n_cmp++; if (wave_out !== 3'b000) begin n_bad++; $display("FAIL reset_wave: got %b expected 000", wave_out); end
        n_cmp++; if (period_strb !== 3'b000) begin n_bad++; $display("FAIL reset_strb: got %b expected 000", period_strb); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int low, per, hi;
        logic e;
        cfg(0, 100000, 128, low, e);
        n_cmp++; if (low !== NUM_W + 2) begin n_bad++; $display("FAIL basic_busy: got %0d expected %0d", low, NUM_W + 2); end
        measure(0, per, hi);
        n_cmp++; if (per !== 1000) begin n_bad++; $display("FAIL basic_period: got %0d expected 1000", per); end
        n_cmp++; if (hi !== 500) begin n_bad++; $display("FAIL basic_high: got %0d expected 500", hi); end
        measure_from_strobe(0, per, hi);
        n_cmp++; if (per !== 1000) begin n_bad++; $display("FAIL basic_period2: got %0d expected 1000", per); end
    endtask

    task automatic test_second_channel();
        int low, per, hi;
        logic e;
        cfg(1, 44000, 64, low, e);
        n_cmp++; if (low !== NUM_W + 2) begin n_bad++; $display("FAIL ch1_busy: got %0d expected %0d", low, NUM_W + 2); end
        measure(1, per, hi);
        n_cmp++; if (per !== 2272) begin n_bad++; $display("FAIL ch1_period: got %0d expected 2272", per); end
        n_cmp++; if (hi !== 568) begin n_bad++; $display("FAIL ch1_high: got %0d expected 568", hi); end
        measure(0, per, hi);
        n_cmp++; if (per !== 1000 || hi !== 500) begin n_bad++; $display("FAIL ch0_kept: got %0d/%0d expected 1000/500", per, hi); end
    endtask

    task automatic test_reject();
        int low, per, hi;
        logic e;
        cfg(0, 1000000, 128, low, e);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rej_freq_err: got %b expected 1", e); end
        n_cmp++; if (low !== 0) begin n_bad++; $display("FAIL rej_freq_ready: got %0d busy cycles expected 0", low); end
        tick();
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_err_pulse: got %b expected 0", cfg_err); end
        cfg(3, 100000, 10, low, e);
        n_cmp++; if (e !== 1'b1 || low !== 0) begin n_bad++; $display("FAIL rej_chan: got err=%b busy=%0d expected err=1 busy=0", e, low); end
        measure(0, per, hi);
        n_cmp++; if (per !== 1000 || hi !== 500) begin n_bad++; $display("FAIL rej_unchanged: got %0d/%0d expected 1000/500", per, hi); end
        cfg(2, 999999, 128, low, e);
        n_cmp++; if (e !== 1'b0 || low !== NUM_W + 2) begin n_bad++; $display("FAIL max_freq_cfg: got err=%b busy=%0d expected err=0 busy=%0d", e, low, NUM_W + 2); end
        measure(2, per, hi);
        n_cmp++; if (per !== 100 || hi !== 50) begin n_bad++; $display("FAIL max_freq_wave: got %0d/%0d expected 100/50", per, hi); end
    endtask

    task automatic test_reconfig();
        int per, hi;
        bit ok;
        wait_strobe(0, 5000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL recfg_sync: got no strobe expected strobe"); end
        per = -1;
        hi  = int'(wave_out[0]);
        for (int k = 1; k <= 3000; k++) begin
            if (k == 300) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'd0;
                cfg_freq  = 32'd200000;
                cfg_duty  = 8'd128;
            end
            tick();
            if (k == 300) cfg_valid = 1'b0;
            if (period_strb[0]) begin
                per = k;
                break;
            end
            hi += int'(wave_out[0]);
        end
        n_cmp++; if (per !== 1000 || hi !== 500) begin n_bad++; $display("FAIL recfg_old_completes: got %0d/%0d expected 1000/500", per, hi); end
        measure_from_strobe(0, per, hi);
        n_cmp++; if (per !== 500 || hi !== 250) begin n_bad++; $display("FAIL recfg_new: got %0d/%0d expected 500/250", per, hi); end
    endtask

    task automatic test_duty_zero_and_silence();
        int low, per, hi, strobes, highs;
        logic e;
        cfg(2, 999999, 0, low, e);
        measure(2, per, hi);
        n_cmp++; if (per !== 100 || hi !== 0) begin n_bad++; $display("FAIL duty0: got %0d/%0d expected 100/0", per, hi); end
        cfg(2, 0, 0, low, e);
        n_cmp++; if (low !== 1) begin n_bad++; $display("FAIL freq0_busy: got %0d expected 1", low); end
        repeat (150) tick();
        strobes = 0;
        highs   = 0;
        repeat (300) begin
            tick();
            strobes += int'(period_strb[2]);
            highs   += int'(wave_out[2]);
        end
        n_cmp++; if (strobes !== 0 || highs !== 0) begin n_bad++; $display("FAIL freq0_idle: got strobes=%0d highs=%0d expected 0/0", strobes, highs); end
    endtask

    task automatic test_enable();
        int per, hi, bad;
        bit ok;
        wait_strobe(0, 5000, ok);
        repeat (10) tick();
        chan_en[0] = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            bad += int'(wave_out[0]) + int'(period_strb[0]);
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL en_off: got %0d active samples expected 0", bad); end
        chan_en[0] = 1'b1;
        #1;
        n_cmp++; if (period_strb[0] !== 1'b1 || wave_out[0] !== 1'b1) begin n_bad++; $display("FAIL en_restart: got strb=%b wave=%b expected 1/1", period_strb[0], wave_out[0]); end
        measure_from_strobe(0, per, hi);
        n_cmp++; if (per !== 500 || hi !== 250) begin n_bad++; $display("FAIL en_period: got %0d/%0d expected 500/250", per, hi); end
    endtask

    task automatic test_reset_during_div();
        int act;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_freq  = 32'd100000;
        cfg_duty  = 8'd128;
        tick();
        cfg_valid = 1'b0;
        repeat (10) tick();
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL div_busy: got %b expected 0", cfg_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b1 || wave_out !== 3'b000 || period_strb !== 3'b000) begin
            n_bad++; $display("FAIL div_reset: got ready=%b wave=%b strb=%b expected 1/000/000", cfg_ready, wave_out, period_strb);
        end
        act = 0;
        repeat (200) begin
            tick();
            act += int'(wave_out[1]) + int'(period_strb[1]);
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL div_no_commit: got %0d active samples expected 0", act); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_channel();
        test_reject();
        test_reconfig();
        test_duty_zero_and_silence();
        test_enable();
        test_reset_during_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
